// File: rtl/pipe_reg_hs.sv
// pipe_reg_hs: valid/ready pipeline register carrying a {pc, instr} payload
// between two pipeline stages.
//
// Storage:
//   - A main entry (M) drives the out_* ports.
//   - With SKID=1 a second skid entry (S) catches one extra payload. This
//     lets in_ready come from a flop (S occupancy) rather than from
//     out_ready.
//
// Control:
//   - pipeline_en=0 freezes every register.
//   - flush empties both entries back to the 0/NOP bubble.
//   - stall_cnt counts back-pressure cycles and saturates at all-ones.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   pipeline_en  global enable; 0 freezes all state and drops in_ready
//   flush        kill all held entries (wins over accept/drain/transfer)
//   in_valid     upstream payload valid
//   in_ready     stage can accept
//   in_pc        upstream pc
//   in_instr     upstream instruction
//   out_valid    payload valid to downstream
//   out_ready    downstream accepts
//   out_pc       held pc (0 while empty)
//   out_instr    held instruction (NOP_INSTR while empty)
//   stall_cnt    saturating back-pressure cycle count (cleared only by rst)

module pipe_reg_hs #(
    parameter int                 PC_W      = 64,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int                 SKID      = 1,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipeline_en,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic               m_valid;
    logic [PC_W-1:0]    m_pc;
    logic [INSTR_W-1:0] m_instr;
    logic               s_valid;
    logic [PC_W-1:0]    s_pc;
    logic [INSTR_W-1:0] s_instr;
    logic               accept;
    logic               drain;
    logic               stall;

    assign out_valid = m_valid;
    assign out_pc    = m_pc;
    assign out_instr = m_instr;

    // With a skid entry, in_ready depends only on the S flop, so there is
    // no combinational path from out_ready to in_ready. Without one, a full
    // M can still accept when it is draining in the same cycle.
    always_comb begin
        in_ready = 1'b0;
        if (!rst && pipeline_en) begin
            if (SKID != 0) begin
                in_ready = !s_valid;
            end else begin
                in_ready = !m_valid || out_ready;
            end
        end
    end

    assign accept = in_valid && in_ready;
    assign drain  = m_valid && out_ready && pipeline_en;
    assign stall  = pipeline_en && m_valid && !out_ready && !flush;

    // Stall counter: saturates at all-ones and is immune to flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Entry storage.
    //   - M refills from S first, which keeps FIFO order; otherwise it takes
    //     the new input.
    //   - An emptied M is forced back to the 0/NOP bubble, so a downstream
    //     stage that ignores valid still sees a harmless NOP.
    //   - S is only loaded when M is full and not draining. That case is
    //     unreachable when SKID=0, because in_ready is then low.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_instr <= NOP_INSTR;
            s_valid <= 1'b0;
            s_pc    <= '0;
            s_instr <= NOP_INSTR;
        end else if (pipeline_en) begin
            if (flush) begin
                m_valid <= 1'b0;
                m_pc    <= '0;
                m_instr <= NOP_INSTR;
                s_valid <= 1'b0;
                s_pc    <= '0;
                s_instr <= NOP_INSTR;
            end else if (!m_valid || drain) begin
                if (s_valid) begin
                    m_valid <= 1'b1;
                    m_pc    <= s_pc;
                    m_instr <= s_instr;
                    s_valid <= 1'b0;
                    s_pc    <= '0;
                    s_instr <= NOP_INSTR;
                end else if (accept) begin
                    m_valid <= 1'b1;
                    m_pc    <= in_pc;
                    m_instr <= in_instr;
                end else begin
                    m_valid <= 1'b0;
                    m_pc    <= '0;
                    m_instr <= NOP_INSTR;
                end
            end else if (accept && (SKID != 0)) begin
                s_valid <= 1'b1;
                s_pc    <= in_pc;
                s_instr <= in_instr;
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_hs.sv
// tb_pipe_reg_hs: self-checking bench for pipe_reg_hs.
//
// Two builds share every input:
//   u_skid  : SKID=1, CNT_W=4 (small counter so saturation is reachable)
//   u_noskid: SKID=0, CNT_W=16
//
// The reference model treats each build as a bounded FIFO queue of payloads
// plus a saturating integer. A directed script with literal expectations runs
// first; randomized traffic follows.

module tb_pipe_reg_hs;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipeline_en;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        rdy_s, val_s;
    logic [63:0] pc_s;
    logic [31:0] instr_s;
    logic [3:0]  cnt_s;

    logic        rdy_n, val_n;
    logic [63:0] pc_n;
    logic [31:0] instr_n;
    logic [15:0] cnt_n;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } payload_t;

    payload_t q_s[$];
    payload_t q_n[$];
    int       m_cnt_s = 0;
    int       m_cnt_n = 0;
    bit       model_ok = 1'b0;

    pipe_reg_hs #(.SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .pipeline_en(pipeline_en), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_s), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(val_s), .out_ready(out_ready), .out_pc(pc_s), .out_instr(instr_s),
        .stall_cnt(cnt_s)
    );

    pipe_reg_hs #(.SKID(0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst(rst), .pipeline_en(pipeline_en), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_n), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(val_n), .out_ready(out_ready), .out_pc(pc_n), .out_instr(instr_n),
        .stall_cnt(cnt_n)
    );

    always #5 clk = ~clk;

    // Readiness follows from queue occupancy.
    //   - Skid build: can take one more while fewer than two are held.
    //   - Single build: needs an empty slot, or one that is leaving.
    function automatic bit model_ready(int occ, bit skid, logic r, logic en, logic ordy);
        if (r || !en) return 1'b0;
        if (skid) return occ < 2;
        return (occ == 0) || ordy;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic fl, input logic iv,
                                 input logic [63:0] pc, input logic [31:0] instr, input logic ordy);
        @(posedge clk);
        #1;
        rst         = r;
        pipeline_en = en;
        flush       = fl;
        in_valid    = iv;
        in_pc       = pc;
        in_instr    = instr;
        out_ready   = ordy;
        @(negedge clk);
    endtask

    // Directed-step shorthand: normal-mode cycle with instr derived from pc.
    task automatic step(input logic fl, input logic iv, input logic [63:0] pc, input logic ordy);
        applyStimulus(1'b0, 1'b1, fl, iv, pc, pc[31:0] + 32'h1000_0000, ordy);
    endtask

    // Model update on each active edge from the pre-edge inputs.
    always @(posedge clk) begin : model_update
        bit acc_s, acc_n, vld_s, vld_n;
        payload_t p;
        if (rst) begin
            q_s.delete();
            q_n.delete();
            m_cnt_s  = 0;
            m_cnt_n  = 0;
            model_ok = 1'b1;
        end else if (pipeline_en) begin
            p.pc    = in_pc;
            p.instr = in_instr;
            vld_s = q_s.size() > 0;
            vld_n = q_n.size() > 0;
            acc_s = in_valid && model_ready(q_s.size(), 1'b1, 1'b0, 1'b1, out_ready);
            acc_n = in_valid && model_ready(q_n.size(), 1'b0, 1'b0, 1'b1, out_ready);
            if (vld_s && !out_ready && !flush && m_cnt_s < 15) m_cnt_s++;
            if (vld_n && !out_ready && !flush && m_cnt_n < 65535) m_cnt_n++;
            if (flush) begin
                q_s.delete();
                q_n.delete();
            end else begin
                if (vld_s && out_ready) void'(q_s.pop_front());
                if (acc_s) q_s.push_back(p);
                if (vld_n && out_ready) void'(q_n.pop_front());
                if (acc_n) q_n.push_back(p);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            checkOutput("s_in_ready", {63'd0, rdy_s},
                        {63'd0, model_ready(q_s.size(), 1'b1, rst, pipeline_en, out_ready)});
            checkOutput("s_out_valid", {63'd0, val_s}, {63'd0, q_s.size() > 0});
            checkOutput("s_out_pc", pc_s, (q_s.size() > 0) ? q_s[0].pc : 64'd0);
            checkOutput("s_out_instr", {32'd0, instr_s}, {32'd0, (q_s.size() > 0) ? q_s[0].instr : NOP});
            checkOutput("s_stall_cnt", {60'd0, cnt_s}, 64'(m_cnt_s));
            checkOutput("n_in_ready", {63'd0, rdy_n},
                        {63'd0, model_ready(q_n.size(), 1'b0, rst, pipeline_en, out_ready)});
            checkOutput("n_out_valid", {63'd0, val_n}, {63'd0, q_n.size() > 0});
            checkOutput("n_out_pc", pc_n, (q_n.size() > 0) ? q_n[0].pc : 64'd0);
            checkOutput("n_out_instr", {32'd0, instr_n}, {32'd0, (q_n.size() > 0) ? q_n[0].instr : NOP});
            checkOutput("n_stall_cnt", {48'd0, cnt_n}, 64'(m_cnt_n));
        end
    end

    initial begin
        rst = 1'b1; pipeline_en = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_instr = '0; out_ready = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready_s", {63'd0, rdy_s}, 64'd0);
        checkOutput("rst_in_ready_n", {63'd0, rdy_n}, 64'd0);

        // Reset state.
        step(1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("rst_valid", {63'd0, val_s}, 64'd0);
        checkOutput("rst_pc", pc_s, 64'd0);
        checkOutput("rst_instr", {32'd0, instr_s}, 64'h13);
        checkOutput("rst_cnt", {60'd0, cnt_s}, 64'd0);
        checkOutput("post_rst_ready", {63'd0, rdy_s}, 64'd1);

        // Streaming at one per cycle.
        step(1'b0, 1'b1, 64'h100, 1'b1);
        checkOutput("stream_ready", {63'd0, rdy_s}, 64'd1);
        step(1'b0, 1'b1, 64'h104, 1'b1);
        checkOutput("stream_pc0_s", pc_s, 64'h100);
        checkOutput("stream_pc0_n", pc_n, 64'h100);
        step(1'b0, 1'b1, 64'h108, 1'b1);
        checkOutput("stream_pc1", pc_s, 64'h104);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("stream_pc2", pc_s, 64'h108);
        checkOutput("stream_instr2", {32'd0, instr_s}, 64'h1000_0108);
        checkOutput("stream_cnt", {60'd0, cnt_s}, 64'd0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("stream_empty", {63'd0, val_s}, 64'd0);

        // Back-pressure into the skid entry.
        step(1'b0, 1'b1, 64'h100, 1'b1);
        step(1'b0, 1'b1, 64'h104, 1'b0);
        checkOutput("bp_skid_ready", {63'd0, rdy_s}, 64'd1);
        checkOutput("bp_noskid_ready", {63'd0, rdy_n}, 64'd0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("bp_full_ready", {63'd0, rdy_s}, 64'd0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("bp_cnt", {60'd0, cnt_s}, 64'd4);
        checkOutput("bp_first", pc_s, 64'h100);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("bp_second", pc_s, 64'h104);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("bp_drained", {63'd0, val_s}, 64'd0);

        // Flush with both entries full and an input offered.
        step(1'b0, 1'b1, 64'h200, 1'b0);
        step(1'b0, 1'b1, 64'h204, 1'b0);
        step(1'b1, 1'b1, 64'h208, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("flush_valid", {63'd0, val_s}, 64'd0);
        checkOutput("flush_pc", pc_s, 64'd0);
        checkOutput("flush_instr", {32'd0, instr_s}, 64'h13);
        checkOutput("flush_cnt", {60'd0, cnt_s}, 64'd5);
        step(1'b1, 1'b1, 64'h20C, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("flush_discard", {63'd0, val_s}, 64'd0);

        // Global freeze.
        step(1'b0, 1'b1, 64'h300, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'h304, 32'h1000_0304, 1'b1);
            checkOutput("freeze_ready", {63'd0, rdy_s}, 64'd0);
            checkOutput("freeze_pc", pc_s, 64'h300);
            checkOutput("freeze_cnt", {60'd0, cnt_s}, 64'd5);
        end
        step(1'b0, 1'b1, 64'h304, 1'b1);
        checkOutput("resume_pc0", pc_s, 64'h300);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("resume_pc1", pc_s, 64'h304);

        // Reset wins over pipeline_en=0.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
        checkOutput("rst_en0_ready", {63'd0, rdy_s}, 64'd0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("rst_en0_cnt", {60'd0, cnt_s}, 64'd0);

        // Saturation of the 4-bit counter.
        step(1'b0, 1'b1, 64'h400, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0);
        checkOutput("sat_cnt", {60'd0, cnt_s}, 64'd15);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("sat_after_flush", {60'd0, cnt_s}, 64'd15);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("sat_rst", {60'd0, cnt_s}, 64'd0);

        // Single-entry build throughput.
        step(1'b0, 1'b1, 64'h500, 1'b1);
        step(1'b0, 1'b1, 64'h504, 1'b1);
        checkOutput("ns_full_ready", {63'd0, rdy_n}, 64'd1);
        checkOutput("ns_pc0", pc_n, 64'h500);
        step(1'b0, 1'b1, 64'h508, 1'b1);
        checkOutput("ns_pc1", pc_n, 64'h504);
        step(1'b0, 1'b1, 64'h50C, 1'b0);
        checkOutput("ns_bp_ready", {63'd0, rdy_n}, 64'd0);
        checkOutput("ns_pc2", pc_n, 64'h508);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        checkOutput("ns_empty", {63'd0, val_n}, 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 7) != 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 3) != 0,
                          {$urandom, $urandom},
                          $urandom,
                          $urandom_range(0, 2) != 0);
        end

        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
